// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-path constants, decoder state enum and address-region helper.
// Holds response codes, default bus widths shared with the arbiter, and the
// 16-bit region compare used by the read decoder.
package axi_pkg;
  localparam int DEF_ID_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [15:0] REGION_BASE = 16'h0000;
  typedef enum logic [2:0] {IDLE, FWD_AR, FWD_R, DEF_AR, DEF_R} state_e;
  // Region index of an address: target k owns ARADDR[31:16] == REGION_BASE + k.
  function automatic logic [15:0] region(input logic [31:0] addr);
    return addr[31:16] - REGION_BASE;
  endfunction
endpackage

// File: rtl/axi_rd_decoder_if.sv
// axi_rd_decoder_if: read-path bundle between the arbiter, the decoder and its targets.
// Upstream AR/R channel plus packed per-target AR handshake and R channels.
// The AR payload is shared, so targets read it directly from this bundle.
// Modports: slave = decoder view, master = arbiter/targets view.
interface axi_rd_decoder_if #(
  parameter int SLAVES = 2,
  parameter int ID_W = axi_pkg::DEF_ID_W,
  parameter int DATA_W = axi_pkg::DEF_DATA_W
);
  logic [ID_W-1:0] ARID;
  logic [31:0] ARADDR;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE;
  logic [1:0] ARBURST;
  logic ARVALID, ARREADY;
  logic [ID_W-1:0] RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0] RRESP;
  logic RLAST, RVALID, RREADY;
  logic [SLAVES-1:0] ARVALID_S, ARREADY_S;
  logic [SLAVES-1:0][ID_W-1:0] RID_S;
  logic [SLAVES-1:0][DATA_W-1:0] RDATA_S;
  logic [SLAVES-1:0][1:0] RRESP_S;
  logic [SLAVES-1:0] RLAST_S, RVALID_S, RREADY_S;
  modport slave (
    input ARID, ARADDR, ARLEN, ARVALID, RREADY, ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID, ARVALID_S, RREADY_S
  );
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input ARREADY, RID, RDATA, RRESP, RLAST, RVALID, ARVALID_S, RREADY_S
  );
endinterface

// File: rtl/axi_default_slave.sv
// axi_default_slave: answers unmapped reads with an ARLEN+1 beat DECERR burst.
// Ports: ACLK/ARESETn; start (AR accepted, capture arid/arlen); active (R phase);
// rready upstream ready; rvalid/rlast/rid/rdata/rresp default R channel (all 0 when inactive).
module axi_default_slave import axi_pkg::*; #(
  parameter int ID_W = DEF_ID_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic start,
  input  logic active,
  input  logic rready,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0] arlen,
  output logic rvalid,
  output logic rlast,
  output logic [ID_W-1:0] rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0] rresp
);
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0] cnt_q, cnt_d;
  // cnt holds beats remaining after the current one, so ARLEN=255 gives 256 beats without wrapping.
  always_comb begin
    id_d = start ? arid : id_q;
    cnt_d = start ? arlen : (active && rready && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    rvalid = active;
    rlast = active && cnt_q == 8'd0;
    rid = active ? id_q : '0;
    rdata = '0;
    rresp = active ? RESP_DECERR : RESP_OKAY;
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      id_q <= '0;
      cnt_q <= '0;
    end else begin
      id_q <= id_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/axi_rd_decoder.sv
// axi_rd_decoder: routes one read transaction at a time to a decoded target or the DECERR default slave.
// Ports: ACLK, ARESETn (async, active-low); bus (slave modport) carrying the upstream
// AR/R channel and the per-target ARVALID_S/ARREADY_S and R channels.
module axi_rd_decoder import axi_pkg::*; #(
  parameter int SLAVES = 2,
  parameter int ID_W = DEF_ID_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic ACLK,
  input logic ARESETn,
  axi_rd_decoder_if.slave bus
);
  state_e state_q, state_d;
  logic [SLAVES-1:0] sel_q, sel_d, hit;
  logic fwd, ar_rdy;
  logic f_valid, f_last, d_valid, d_last;
  logic [ID_W-1:0] f_id, d_id;
  logic [DATA_W-1:0] f_data, d_data;
  logic [1:0] f_resp, d_resp;
  axi_default_slave #(.ID_W(ID_W), .DATA_W(DATA_W)) u_def (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .start(state_q == DEF_AR), .active(state_q == DEF_R), .rready(bus.RREADY),
    .arid(bus.ARID), .arlen(bus.ARLEN),
    .rvalid(d_valid), .rlast(d_last), .rid(d_id), .rdata(d_data), .rresp(d_resp)
  );
  // One-hot decode plus AND-OR mux of the selected target's R channel.
  always_comb begin
    f_valid = 1'b0;
    f_last = 1'b0;
    f_id = '0;
    f_data = '0;
    f_resp = '0;
    for (int k = 0; k < SLAVES; k++) begin
      hit[k] = region(bus.ARADDR) == 16'(k);
      f_valid = f_valid | (sel_q[k] & bus.RVALID_S[k]);
      f_last = f_last | (sel_q[k] & bus.RLAST_S[k]);
      f_id = f_id | (sel_q[k] ? bus.RID_S[k] : '0);
      f_data = f_data | (sel_q[k] ? bus.RDATA_S[k] : '0);
      f_resp = f_resp | (sel_q[k] ? bus.RRESP_S[k] : '0);
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    fwd = state_q == FWD_R;
    ar_rdy = 1'b0;
    bus.ARVALID_S = '0;
    bus.RREADY_S = '0;
    case (state_q)
      IDLE: if (bus.ARVALID) begin
        sel_d = hit;
        state_d = |hit ? FWD_AR : DEF_AR;
      end
      FWD_AR: begin
        bus.ARVALID_S = sel_q;
        ar_rdy = |(bus.ARREADY_S & sel_q);
        state_d = (bus.ARVALID && ar_rdy) ? FWD_R : FWD_AR;
      end
      FWD_R: begin
        bus.RREADY_S = sel_q & {SLAVES{bus.RREADY}};
        state_d = (f_valid && bus.RREADY && f_last) ? IDLE : FWD_R;
      end
      DEF_AR: begin
        ar_rdy = 1'b1;
        state_d = DEF_R;
      end
      DEF_R: state_d = (d_last && bus.RREADY) ? IDLE : DEF_R;
      default: state_d = IDLE;
    endcase
    bus.ARREADY = ar_rdy;
    bus.RVALID = fwd ? f_valid : d_valid;
    bus.RLAST = fwd ? f_last : d_last;
    bus.RID = fwd ? f_id : d_id;
    bus.RDATA = fwd ? f_data : d_data;
    bus.RRESP = fwd ? f_resp : d_resp;
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state_q <= IDLE;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
    end
endmodule

// File: tb/tb_axi_rd_decoder.sv
// tb_axi_rd_decoder: directed bench with target models and an R-beat scoreboard.
module tb_axi_rd_decoder;
  import axi_pkg::*;
  typedef struct {
    logic [7:0] id;
    logic [31:0] data;
    logic [1:0] resp;
    logic last;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_fail = 0;
  int n_beats = 0;
  beat_t sb[$];
  logic [1:0] av_allowed, rs_allowed, spur;
  int ar_delay[2];
  int rem[2];
  int avc[2];
  logic [7:0] bidx[2];
  logic [7:0] tid[2];
  always #5 clk = ~clk;
  axi_rd_decoder_if #(.SLAVES(2), .ID_W(8), .DATA_W(32)) bus ();
  axi_rd_decoder #(.SLAVES(2), .ID_W(8), .DATA_W(32)) dut (.ACLK(clk), .ARESETn(rst_n), .bus(bus));
  function automatic logic [31:0] tdata(input int k, input logic [7:0] i);
    return {8'hA0 + 8'(k), 16'h5500, i};
  endfunction
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  // Target models: AR ready after ar_delay cycles of ARVALID_S, then ARLEN+1 OKAY beats.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] <= 0;
        avc[k] <= 0;
        bidx[k] <= '0;
        tid[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        avc[k] <= (bus.ARVALID_S[k] && !bus.ARREADY_S[k]) ? avc[k] + 1 : 0;
        if (bus.ARVALID_S[k] && bus.ARREADY_S[k]) begin
          rem[k] <= int'(bus.ARLEN) + 1;
          bidx[k] <= '0;
          tid[k] <= bus.ARID;
        end else if (bus.RVALID_S[k] && bus.RREADY_S[k] && rem[k] > 0) begin
          rem[k] <= rem[k] - 1;
          bidx[k] <= bidx[k] + 8'd1;
        end
      end
    end
  always_comb
    for (int k = 0; k < 2; k++) begin
      bus.ARREADY_S[k] = bus.ARVALID_S[k] && avc[k] >= ar_delay[k];
      bus.RVALID_S[k] = rem[k] != 0 || spur[k];
      bus.RLAST_S[k] = rem[k] == 1;
      bus.RID_S[k] = tid[k];
      bus.RDATA_S[k] = tdata(k, bidx[k]);
      bus.RRESP_S[k] = RESP_OKAY;
    end
  // Monitor: per-cycle select masks and scoreboard compare of every upstream R handshake.
  always @(negedge clk)
    if (rst_n) begin
      chk("arvalid_s_mask", 64'(bus.ARVALID_S & ~av_allowed), 64'd0);
      chk("rready_s_mask", 64'(bus.RREADY_S & ~rs_allowed), 64'd0);
      if (bus.RVALID && bus.RREADY) begin
        chk("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("rid", 64'(bus.RID), 64'(e.id));
          chk("rdata", 64'(bus.RDATA), 64'(e.data));
          chk("rresp", 64'(bus.RRESP), 64'(e.resp));
          chk("rlast", 64'(bus.RLAST), 64'(e.last));
          n_beats++;
        end
      end
    end
  task automatic all_outs_zero(input string tag);
    chk(tag, {bus.ARREADY, bus.RVALID, bus.RLAST, bus.RID, bus.RDATA, bus.RRESP, bus.ARVALID_S, bus.RREADY_S}, 64'd0);
  endtask
  // Issues one request (caller aligned just after a posedge) and returns the FWD_AR wait in cycles.
  task automatic ar_req(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len, input int tgt, output int waited);
    logic [1:0] exp_av;
    exp_av = (tgt < 0) ? 2'b00 : 2'(1 << tgt);
    for (int i = 0; i <= int'(len); i++) begin
      beat_t b;
      b.id = id;
      b.data = (tgt < 0) ? 32'h0 : tdata(tgt, 8'(i));
      b.resp = (tgt < 0) ? RESP_DECERR : RESP_OKAY;
      b.last = i == int'(len);
      sb.push_back(b);
    end
    bus.ARID = id;
    bus.ARADDR = addr;
    bus.ARLEN = len;
    bus.ARSIZE = 3'd2;
    bus.ARBURST = 2'b01;
    bus.ARVALID = 1'b1;
    @(negedge clk);
    chk("arvalid_s_in_idle", 64'(bus.ARVALID_S), 64'd0);
    chk("arready_in_idle", 64'(bus.ARREADY), 64'd0);
    @(negedge clk);
    chk("arvalid_s_decode", 64'(bus.ARVALID_S), 64'(exp_av));
    waited = 0;
    while (!bus.ARREADY && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("ar_handshake", 64'(bus.ARREADY), 64'd1);
    @(posedge clk);
    #1 bus.ARVALID = 1'b0;
  endtask
  task automatic drain(input bit toggle, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1 if (toggle) bus.RREADY = ~bus.RREADY;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    bus.RREADY = 1'b1;
  endtask
  task automatic idle_check(input string tag, input int base, input int beats);
    @(negedge clk);
    chk({tag, "_rvalid_after"}, 64'(bus.RVALID), 64'd0);
    chk({tag, "_arready_after"}, 64'(bus.ARREADY), 64'd0);
    chk({tag, "_beats"}, 64'(n_beats - base), 64'(beats));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int w, base;
    rst_n = 1'b0;
    bus.ARID = '0;
    bus.ARADDR = '0;
    bus.ARLEN = '0;
    bus.ARSIZE = '0;
    bus.ARBURST = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    ar_delay[0] = 0;
    ar_delay[1] = 0;
    spur = 2'b00;
    av_allowed = 2'b11;
    rs_allowed = 2'b11;
    #2 all_outs_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Target 0, ready at once, 4 beats.
    av_allowed = 2'b01;
    rs_allowed = 2'b01;
    base = n_beats;
    ar_req(8'h11, 32'h0000_0040, 8'd3, 0, w);
    chk("t0_ar_wait", 64'(w), 64'd0);
    drain(1'b0, 50);
    idle_check("t0", base, 4);
    // Target 1 stalls AR for 5 cycles.
    ar_delay[1] = 5;
    av_allowed = 2'b10;
    rs_allowed = 2'b10;
    base = n_beats;
    ar_req(8'h22, 32'h0001_0000, 8'd1, 1, w);
    chk("t1_ar_wait", 64'(w), 64'd5);
    drain(1'b0, 50);
    idle_check("t1", base, 2);
    ar_delay[1] = 0;
    // Default slave, 3 DECERR beats, no target request.
    av_allowed = 2'b00;
    rs_allowed = 2'b00;
    base = n_beats;
    ar_req(8'h5A, 32'h8000_0000, 8'd2, -1, w);
    chk("def_ar_wait", 64'(w), 64'd0);
    drain(1'b0, 50);
    idle_check("def3", base, 3);
    // First region past the last target, 256 beats, RREADY toggling.
    base = n_beats;
    ar_req(8'hC3, 32'h0002_0000, 8'd255, -1, w);
    drain(1'b1, 1200);
    idle_check("def256", base, 256);
    // Spurious target-1 RVALID during a target-0 burst.
    av_allowed = 2'b01;
    rs_allowed = 2'b01;
    spur = 2'b10;
    base = n_beats;
    ar_req(8'h33, 32'h0000_1234, 8'd3, 0, w);
    drain(1'b0, 50);
    spur = 2'b00;
    idle_check("spur", base, 4);
    // Asynchronous reset while beat 2 of 4 is presented.
    base = n_beats;
    ar_req(8'h44, 32'h0000_0000, 8'd3, 0, w);
    @(posedge clk);
    #3 chk("rst_mid_beats", 64'(n_beats - base), 64'd1);
    chk("rst_mid_rvalid_before", 64'(bus.RVALID), 64'd1);
    rst_n = 1'b0;
    #1 all_outs_zero("async_reset_outputs");
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    av_allowed = 2'b10;
    rs_allowed = 2'b10;
    base = n_beats;
    ar_req(8'h55, 32'h0001_0008, 8'd1, 1, w);
    drain(1'b0, 50);
    idle_check("post_rst", base, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
